// File: rtl/hls_test_sequencer.sv
// Test sequencer for HLS kernels using the req/busy/return handshake: resets the kernels,
// requests them (all together or one at a time), tracks completion/timeout and reports pass/fail.
// Define SEQ_REPORT_EN for simulation-only per-channel and summary reporting.
module hls_test_sequencer #(
    parameter int NUM_CH    = 4,
    parameter int SEQ_MODE  = 0,
    parameter int RST_LEN   = 6,
    parameter int REQ_DELAY = 92,
    parameter int SETTLE    = 5,
    parameter int TIMEOUT   = 10000,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              dut_reset,
    output logic [NUM_CH-1:0] test_req,
    input  logic [NUM_CH-1:0] test_busy,
    input  logic [NUM_CH-1:0] test_return,
    output logic              done,
    output logic              pass,
    output logic [NUM_CH-1:0] fail_mask,
    output logic [NUM_CH-1:0] timeout_mask,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RST    = 3'd1;
    localparam logic [2:0] S_DELAY  = 3'd2;
    localparam logic [2:0] S_REQ    = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;
    localparam logic [2:0] S_NEXT   = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_LEN - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REQ_DELAY - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] TMO         = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CH - 1);

    logic [2:0]        state;
    logic [CNT_W-1:0]  phase_cnt;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [IDX_W-1:0]  ch_idx;
    logic [NUM_CH-1:0] finished;
    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] busy_done;
    logic [NUM_CH-1:0] timed;
    logic              all_finished;
    logic              more_channels;

    // The timeout counter reads 1 in the REQ cycle, so TIMEOUT is reached on the
    // TIMEOUT-th cycle of the request; busy is checked first so that cycle still passes.
    always_comb begin
        active = '0;
        if (SEQ_MODE == 0) begin
            active = '1;
        end else begin
            active[ch_idx] = 1'b1;
        end
        pending      = active & ~finished;
        busy_done    = pending & ~test_busy;
        timed        = (tmo_cnt >= TMO) ? (pending & test_busy) : '0;
        all_finished = (((finished | busy_done | timed) & active) == active);
        more_channels = (SEQ_MODE != 0) && (ch_idx != LAST_IDX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            dut_reset    <= 1'b0;
            test_req     <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail_mask    <= '0;
            timeout_mask <= '0;
            cycle_count  <= '0;
            phase_cnt    <= '0;
            tmo_cnt      <= '0;
            ch_idx       <= '0;
            finished     <= '0;
        end else begin
            if (state != S_IDLE && state != S_DONE && cycle_count != '1) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if ((state == S_REQ || state == S_SETTLE || state == S_RUN) && tmo_cnt < TMO) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state        <= S_RST;
                        dut_reset    <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        fail_mask    <= '0;
                        timeout_mask <= '0;
                        cycle_count  <= '0;
                        phase_cnt    <= '0;
                        ch_idx       <= '0;
                    end
                end
                S_RST: begin
                    if (phase_cnt == RST_LAST) begin
                        dut_reset <= 1'b0;
                        phase_cnt <= '0;
                        state     <= S_DELAY;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                S_DELAY: begin
                    if (phase_cnt == DELAY_LAST) begin
                        test_req  <= active;
                        tmo_cnt   <= CNT_W'(1);
                        finished  <= '0;
                        phase_cnt <= '0;
                        state     <= S_REQ;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                S_REQ: begin
                    state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (phase_cnt == SETTLE_LAST) begin
                        phase_cnt <= '0;
                        state     <= S_RUN;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    finished     <= finished | busy_done | timed;
                    test_req     <= test_req & ~(busy_done | timed);
                    fail_mask    <= fail_mask | (busy_done & ~test_return) | timed;
                    timeout_mask <= timeout_mask | timed;
                    if (all_finished) begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (more_channels) begin
                        ch_idx    <= ch_idx + 1'b1;
                        dut_reset <= 1'b1;
                        phase_cnt <= '0;
                        state     <= S_RST;
                    end else begin
                        test_req <= '0;
                        done     <= 1'b1;
                        pass     <= (fail_mask == '0);
                        state    <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SEQ_REPORT_EN
    logic done_d;

    always @(posedge clk) begin
        done_d <= done;
        if (reset && state == S_RUN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (timed[i]) begin
                    $display("ch%0d: TEST TIMEOUT", i);
                end else if (busy_done[i]) begin
                    if (test_return[i]) $display("ch%0d: TEST SUCCESS", i);
                    else                $display("ch%0d: TEST *** FAILURE ***", i);
                end
            end
        end
        if (done && !done_d) begin
            $display("hls_test_sequencer: run complete, pass=%0b, cycle_count=%0d", pass, cycle_count);
            if (!pass) $fatal(1, "hls_test_sequencer: one or more channels did not pass");
        end
    end
`else
    // Synthesis build: no reporting logic.
`endif

endmodule

// File: tb/tb_hls_test_sequencer.sv
// Directed bench for hls_test_sequencer: a parallel-mode and a sequential-mode instance
// driven by simple kernel models with per-channel busy latency and return value.
module tb_hls_test_sequencer;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       start = '0;
    logic [1:0][3:0]  busy;
    logic [1:0][3:0]  rv = '0;
    wire  [1:0]       dut_reset;
    wire  [1:0][3:0]  req;
    wire  [1:0]       done;
    wire  [1:0]       pass;
    wire  [1:0][3:0]  fm;
    wire  [1:0][3:0]  tm;
    wire  [1:0][31:0] cc;

    int lat  [2][4];
    int kcnt [2][4];

    int checks = 0;
    int errors = 0;

    int w_ok, w_rst_cyc, w_pulses, w_first_req, w_multi, w_code, w_done_at;
    int w_drop [4];

    always #5 clk = ~clk;

    hls_test_sequencer #(.NUM_CH(4), .SEQ_MODE(0), .TIMEOUT(200)) u_par (
        .clk(clk), .reset(reset), .start(start[0]), .dut_reset(dut_reset[0]),
        .test_req(req[0]), .test_busy(busy[0]), .test_return(rv[0]),
        .done(done[0]), .pass(pass[0]), .fail_mask(fm[0]), .timeout_mask(tm[0]),
        .cycle_count(cc[0])
    );

    hls_test_sequencer #(.NUM_CH(4), .SEQ_MODE(1), .TIMEOUT(200)) u_seq (
        .clk(clk), .reset(reset), .start(start[1]), .dut_reset(dut_reset[1]),
        .test_req(req[1]), .test_busy(busy[1]), .test_return(rv[1]),
        .done(done[1]), .pass(pass[1]), .fail_mask(fm[1]), .timeout_mask(tm[1]),
        .cycle_count(cc[1])
    );

    // Kernel model: busy while req is high and fewer than lat cycles have passed since req rose.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++)
                kcnt[d][c] <= req[d][c] ? kcnt[d][c] + 1 : 0;
    end

    always_comb begin
        busy = '0;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++)
                busy[d][c] = req[d][c] && (kcnt[d][c] < lat[d][c]);
    end

    task automatic set_kernels(input int d, input int l0, input int l1, input int l2,
                               input int l3, input logic [3:0] ret);
        lat[d][0] = l0; lat[d][1] = l1; lat[d][2] = l2; lat[d][3] = l3;
        rv[d] = ret;
    endtask

    // Pulses start and watches the run; sample i is taken at the negedge after edge S+i.
    task automatic run_watch(input int d, input int mid_start);
        logic       prev_rst;
        logic [3:0] prev_req;
        logic [3:0] hi;
        w_ok = 0; w_rst_cyc = 0; w_pulses = 0; w_first_req = -1; w_multi = 0;
        w_code = 0; w_done_at = -1;
        for (int c = 0; c < 4; c++) w_drop[c] = -1;
        prev_rst = 1'b0; prev_req = '0; hi = '0;
        @(negedge clk) start[d] = 1'b1;
        @(negedge clk) start[d] = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (dut_reset[d]) begin
                w_rst_cyc++;
                if (!prev_rst) w_pulses++;
            end
            prev_rst = dut_reset[d];
            if (req[d] != '0 && w_first_req < 0) w_first_req = i;
            if ($countones(req[d]) > 1) w_multi = 1;
            if (req[d] != '0 && prev_req == '0) begin
                for (int c = 3; c >= 0; c--)
                    if (req[d][c]) w_code = (w_code / 10 == w_code / 10) ? w_code : w_code;
                begin
                    int low;
                    low = 0;
                    for (int c = 3; c >= 0; c--) if (req[d][c]) low = c;
                    w_code = w_code * 10 + low + 1;
                end
            end
            prev_req = req[d];
            for (int c = 0; c < 4; c++) begin
                if (req[d][c]) hi[c] = 1'b1;
                else if (hi[c] && w_drop[c] < 0) w_drop[c] = i;
            end
            if (done[d]) begin
                w_ok = 1;
                w_done_at = i;
                break;
            end
            if (i == mid_start) start[d] = 1'b1;
            @(negedge clk);
            start[d] = 1'b0;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({dut_reset[d], req[d], done[d], pass[d], fm[d], tm[d], cc[d]} !== '0)
                $display("[TB] FAIL reset_outputs inst%0d: got dut_reset=%b req=%b done=%b pass=%b fm=%b tm=%b cc=%0d, want all 0",
                         d, dut_reset[d], req[d], done[d], pass[d], fm[d], tm[d], cc[d]);
            if ({dut_reset[d], req[d], done[d], pass[d], fm[d], tm[d], cc[d]} !== '0) errors++;
        end
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_parallel_pass;
        set_kernels(0, 50, 50, 50, 50, 4'b1111);
        run_watch(0, -1);
        checks++; if (w_ok != 1) begin errors++; $display("[TB] FAIL par_done: got done_seen=%0d, want 1", w_ok); end
        checks++; if (w_rst_cyc != 6) begin errors++; $display("[TB] FAIL par_rst_len: got %0d, want 6", w_rst_cyc); end
        checks++; if (w_first_req != 98) begin errors++; $display("[TB] FAIL par_req_rise: got %0d, want 98", w_first_req); end
        checks++; if (w_done_at != 150) begin errors++; $display("[TB] FAIL par_done_at: got %0d, want 150", w_done_at); end
        checks++; if (pass[0] !== 1'b1) begin errors++; $display("[TB] FAIL par_pass: got %b, want 1", pass[0]); end
        checks++; if (fm[0] !== 4'b0000 || tm[0] !== 4'b0000) begin errors++; $display("[TB] FAIL par_masks: got fm=%b tm=%b, want 0000 0000", fm[0], tm[0]); end
        checks++; if (cc[0] !== 32'd150) begin errors++; $display("[TB] FAIL par_cycles: got %0d, want 150", cc[0]); end
        repeat (5) @(negedge clk);
        checks++; if (cc[0] !== 32'd150 || done[0] !== 1'b1 || req[0] !== 4'b0000) begin
            errors++; $display("[TB] FAIL par_hold: got cc=%0d done=%b req=%b, want 150 1 0000", cc[0], done[0], req[0]);
        end
    endtask

    task automatic test_mixed;
        set_kernels(0, 30, 30, 30, 30, 4'b1011);
        run_watch(0, -1);
        checks++; if (w_ok != 1) begin errors++; $display("[TB] FAIL mix_done: got done_seen=%0d, want 1", w_ok); end
        checks++; if (pass[0] !== 1'b0) begin errors++; $display("[TB] FAIL mix_pass: got %b, want 0", pass[0]); end
        checks++; if (fm[0] !== 4'b0100) begin errors++; $display("[TB] FAIL mix_fail_mask: got %b, want 0100", fm[0]); end
        checks++; if (tm[0] !== 4'b0000) begin errors++; $display("[TB] FAIL mix_timeout_mask: got %b, want 0000", tm[0]); end
        checks++; if (cc[0] !== 32'd130) begin errors++; $display("[TB] FAIL mix_cycles: got %0d, want 130", cc[0]); end
    endtask

    task automatic test_timeout;
        set_kernels(0, 50, 1000000, 50, 50, 4'b1111);
        run_watch(0, -1);
        checks++; if (w_ok != 1) begin errors++; $display("[TB] FAIL tmo_done: got done_seen=%0d, want 1", w_ok); end
        checks++; if (w_drop[1] != 298) begin errors++; $display("[TB] FAIL tmo_req_drop: got %0d, want 298", w_drop[1]); end
        checks++; if (tm[0] !== 4'b0010 || fm[0] !== 4'b0010) begin errors++; $display("[TB] FAIL tmo_masks: got tm=%b fm=%b, want 0010 0010", tm[0], fm[0]); end
        checks++; if (pass[0] !== 1'b0) begin errors++; $display("[TB] FAIL tmo_pass: got %b, want 0", pass[0]); end
        checks++; if (cc[0] !== 32'd299) begin errors++; $display("[TB] FAIL tmo_cycles: got %0d, want 299", cc[0]); end
    endtask

    task automatic test_boundaries;
        set_kernels(0, 0, 199, 200, 10, 4'b1111);
        run_watch(0, -1);
        checks++; if (w_ok != 1) begin errors++; $display("[TB] FAIL bnd_done: got done_seen=%0d, want 1", w_ok); end
        checks++; if (w_drop[0] != 105) begin errors++; $display("[TB] FAIL bnd_settle_ignore: got drop %0d, want 105", w_drop[0]); end
        checks++; if (w_drop[1] != 298) begin errors++; $display("[TB] FAIL bnd_exact_timeout_drop: got %0d, want 298", w_drop[1]); end
        checks++; if (w_drop[3] != 109) begin errors++; $display("[TB] FAIL bnd_ch3_drop: got %0d, want 109", w_drop[3]); end
        checks++; if (fm[0] !== 4'b0100 || tm[0] !== 4'b0100) begin errors++; $display("[TB] FAIL bnd_masks: got fm=%b tm=%b, want 0100 0100", fm[0], tm[0]); end
        checks++; if (cc[0] !== 32'd299) begin errors++; $display("[TB] FAIL bnd_cycles: got %0d, want 299", cc[0]); end
    endtask

    task automatic test_sequential;
        set_kernels(1, 20, 20, 20, 20, 4'b1111);
        run_watch(1, -1);
        checks++; if (w_ok != 1) begin errors++; $display("[TB] FAIL seq_done: got done_seen=%0d, want 1", w_ok); end
        checks++; if (w_pulses != 4 || w_rst_cyc != 24) begin errors++; $display("[TB] FAIL seq_resets: got pulses=%0d cycles=%0d, want 4 24", w_pulses, w_rst_cyc); end
        checks++; if (w_multi != 0) begin errors++; $display("[TB] FAIL seq_one_hot: got multi=%0d, want 0", w_multi); end
        checks++; if (w_code != 1234) begin errors++; $display("[TB] FAIL seq_order: got %0d, want 1234", w_code); end
        checks++; if (pass[1] !== 1'b1 || fm[1] !== 4'b0000) begin errors++; $display("[TB] FAIL seq_pass: got pass=%b fm=%b, want 1 0000", pass[1], fm[1]); end
        checks++; if (cc[1] !== 32'd480) begin errors++; $display("[TB] FAIL seq_cycles: got %0d, want 480", cc[1]); end
    endtask

    task automatic test_start_midrun;
        set_kernels(0, 40, 40, 40, 40, 4'b1111);
        run_watch(0, 120);
        checks++; if (w_ok != 1 || w_pulses != 1) begin errors++; $display("[TB] FAIL midstart_flow: got done_seen=%0d pulses=%0d, want 1 1", w_ok, w_pulses); end
        checks++; if (cc[0] !== 32'd140 || pass[0] !== 1'b1) begin errors++; $display("[TB] FAIL midstart_result: got cc=%0d pass=%b, want 140 1", cc[0], pass[0]); end
    endtask

    task automatic test_reset_midrun;
        int seen;
        set_kernels(0, 40, 40, 40, 40, 4'b1111);
        @(negedge clk) start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (req[0] != '0) seen = 1;
            else @(negedge clk);
        end
        checks++; if (seen != 1) begin errors++; $display("[TB] FAIL rstmid_req_seen: got %0d, want 1", seen); end
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({dut_reset[0], req[0], done[0], pass[0], fm[0], tm[0], cc[0]} !== '0) begin
            errors++;
            $display("[TB] FAIL rstmid_async_clear: got dut_reset=%b req=%b done=%b cc=%0d, want all 0",
                     dut_reset[0], req[0], done[0], cc[0]);
        end
        @(negedge clk) reset = 1'b1;
        set_kernels(0, 20, 20, 20, 20, 4'b1111);
        run_watch(0, -1);
        checks++; if (w_ok != 1 || pass[0] !== 1'b1 || cc[0] !== 32'd120) begin
            errors++; $display("[TB] FAIL rstmid_rerun: got done_seen=%0d pass=%b cc=%0d, want 1 1 120", w_ok, pass[0], cc[0]);
        end
    endtask

    initial begin
        set_kernels(0, 50, 50, 50, 50, 4'b1111);
        set_kernels(1, 20, 20, 20, 20, 4'b1111);
        test_reset();
        test_parallel_pass();
        test_mixed();
        test_timeout();
        test_boundaries();
        test_sequential();
        test_start_midrun();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hls_test_sequencer.md
Name: hls_test_sequencer

Overview:
- Synthesisable, parametrised test sequencer for HLS-generated kernels that use the req/busy/return protocol.
- Generates the kernel reset pulse and waits a programmable delay. It then issues test_req to NUM_CH kernels, either in parallel or one at a time.
- Detects completion per channel, with a per-channel cycle timeout. Aggregates pass/fail and raises done.
- Sits between a bench or on-chip self-test controller and the kernels under test.

Parameters:
- NUM_CH, 4, number of kernel channels (1..32).
- SEQ_MODE, 0: 0 = all channels requested together; 1 = channels run one at a time, index 0 upward.
- RST_LEN, 6, number of cycles dut_reset is held high.
- REQ_DELAY, 92, idle cycles between dut_reset falling and the first req.
- SETTLE, 5, cycles after req rises before busy is sampled.
- TIMEOUT, 10000, maximum cycles a channel may take from req rising before it is declared timed out.
- CNT_W, 32, width of the cycle counters.

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle pulse; begins a run; ignored unless in IDLE or DONE.
- dut_reset, out, 1: active-high reset to all kernels.
- test_req, out, NUM_CH: per-channel request.
- test_busy, in, NUM_CH: per-channel busy.
- test_return, in, NUM_CH: per-channel boolean result.
- done, out, 1: run complete; level.
- pass, out, 1: 1 when done and every channel returned 1 without timeout.
- fail_mask, out, NUM_CH: bit i set = channel i returned 0 or timed out.
- timeout_mask, out, NUM_CH: bit i set = channel i timed out.
- cycle_count, out, CNT_W: cycles since start; frozen at done.

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE. All outputs 0, all counters 0, channel index 0.
- States: IDLE, RST, DELAY, REQ, SETTLE, RUN, NEXT, DONE.
- IDLE/DONE, on start:
  - go to RST.
  - clear done, pass, fail_mask, timeout_mask and cycle_count.
  - dut_reset goes high on the next edge.
- RST: hold dut_reset = 1 for exactly RST_LEN cycles, then go to DELAY with dut_reset = 0.
- DELAY: exactly REQ_DELAY cycles, then REQ.
- REQ (1 cycle): raise test_req on the active set and clear the timeout counter.
  - SEQ_MODE = 0: the active set is all bits.
  - SEQ_MODE = 1: the active set is the current index bit only.
- SETTLE: SETTLE cycles; busy is ignored; req stays high.
- RUN: each cycle, for every active channel not yet finished:
  - test_busy = 0: mark finished, latch test_return into the result, drop that channel's test_req on the next edge.
  - timeout counter reaches TIMEOUT with busy still 1: mark finished, set timeout_mask and fail_mask bits, drop req.
  - When all active channels are finished, go to NEXT.
- NEXT:
  - SEQ_MODE = 1 and index < NUM_CH-1: increment index, go to RST (each channel gets its own reset pulse).
  - Otherwise go to DONE.
- DONE:
  - done = 1.
  - pass = 1 when fail_mask == 0.
  - All req bits 0; outputs held until the next start.
- Timeout counter: counts from the REQ cycle and includes the SETTLE cycles. A channel that finishes on the exact TIMEOUT cycle counts as success, not timeout.
- cycle_count increments every cycle from the first RST cycle through the NEXT cycle preceding DONE. It saturates at all-ones and does not wrap.
- start asserted in any state other than IDLE/DONE: ignored.
- Reset asserted mid-run: immediate return to IDLE; dut_reset and test_req drop asynchronously.
- test_busy or test_return changes on inactive channels: ignored.

Optional Feature:
- Macro: SEQ_REPORT_EN.
- Defined: simulation-only reporting.
  - On each channel finish, $display prints "chN: TEST SUCCESS", "chN: TEST *** FAILURE ***" or "chN: TEST TIMEOUT".
  - On entering DONE, $display prints a summary line with cycle_count.
  - If pass = 0, $fatal(1) is called.
- Undefined: no system tasks; pure synthesisable RTL; port list unchanged.

Test Plan:
- Parallel pass: NUM_CH = 4, SEQ_MODE = 0, start at cycle 0; all busy fall at 50 cycles after req with return = 1.
  - Expected: dut_reset high for 6 cycles; req high 98 cycles after start; done with pass = 1 and fail_mask = 0.
- Mixed result: channel 2 returns 0 and the rest return 1.
  - Expected: pass = 0, fail_mask = 4'b0100, timeout_mask = 0.
- Timeout: TIMEOUT = 200; channel 1 busy stuck at 1.
  - Expected: channel 1 req drops exactly 200 cycles after req rises; timeout_mask = fail_mask = 4'b0010; done = 1.
- Sequential: SEQ_MODE = 1, all pass.
  - Expected: 4 separate 6-cycle dut_reset pulses; only one req bit high at a time, in index order; pass = 1.
- Boundaries:
  - busy low during SETTLE is ignored; completion is recognised on the first RUN cycle.
  - Channel finishing on cycle TIMEOUT passes.
- Robustness:
  - start pulsed mid-run: no effect.
  - reset driven low mid-RUN: all outputs 0 with no clock edge needed; a new start afterwards completes normally.
